// File: rtl/device_write_controller_if.sv
// Bundles the CPU data port, the data-memory port, the output-device
// handshake and the controller status flags into one set of wires.
// The controller connects through the slave modport. The surrounding
// system connects through the master modport. That system is the CPU,
// the data memory and the device.
interface device_write_controller_if;
  logic        memWriteIn;
  logic        readDataIn;
  logic [31:0] addressIn;
  logic [31:0] dataIn;

  logic        memWriteOut;
  logic        readDataOut;
  logic [31:0] addressOut;
  logic [31:0] dataOut;
  logic        cpuStall;

  logic [31:0] devData;
  logic        devValid;
  logic        devReady;
  logic        devFinish;

  logic        busy;
  logic        error;

  modport slave (
    input  memWriteIn, readDataIn, addressIn, dataIn,
    input  devReady, devFinish,
    output memWriteOut, readDataOut, addressOut, dataOut, cpuStall,
    output devData, devValid, busy, error
  );

  modport master (
    output memWriteIn, readDataIn, addressIn, dataIn,
    output devReady, devFinish,
    input  memWriteOut, readDataOut, addressOut, dataOut, cpuStall,
    input  devData, devValid, busy, error
  );
endinterface

// File: rtl/device_write_controller.sv
// Sequences CPU stores to the memory-mapped output device.
// A store to DEVICE_ADDR is swallowed and never reaches data memory.
// The controller then does the following, in order:
//   - writes a busy word (1) to STATUS_ADDR;
//   - offers the data word to the device over valid/ready;
//   - waits for the device's finish level;
//   - writes done (0) or timeout (2) back to STATUS_ADDR.
// The controller borrows the shared memory write port only for the two
// status-write cycles. The CPU is stalled for those two cycles.
module device_write_controller #(
  parameter logic [31:0] DEVICE_ADDR    = 32'h0000_0001,
  parameter logic [31:0] STATUS_ADDR    = 32'h0000_FFFC,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic                      clock,
  input  logic                      reset_n,
  device_write_controller_if.slave  bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [31:0] STATUS_DONE  = 32'd0;
  localparam logic [31:0] STATUS_BUSY  = 32'd1;
  localparam logic [31:0] STATUS_ERROR = 32'd2;

  typedef enum logic [2:0] {
    IDLE,
    SET_BUSY,
    SEND,
    WAIT_DONE,
    CLR_BUSY
  } stateT;

  stateT            state;
  stateT            nextState;
  logic [31:0]      devDataQ;
  logic [31:0]      devDataNext;
  logic             devValidQ;
  logic             devValidNext;
  logic             errorQ;
  logic             errorNext;
  logic [31:0]      statusVal;
  logic [31:0]      statusNext;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] counterNext;
  logic             deviceStore;
  logic             timeoutHit;
  logic             ownsPort;
  logic [CNT_W-1:0] counterInc;

  assign deviceStore = bus.memWriteIn && (bus.addressIn == DEVICE_ADDR);
  assign timeoutHit  = (counter == CNT_LAST);
  assign ownsPort    = (state == SET_BUSY) || (state == CLR_BUSY);
  assign counterInc  = (counter == CNT_MAX) ? counter : counter + CNT_ONE;

  // Register state, the captured device word and the status/timeout
  // bookkeeping. A reset mid-transfer simply drops everything.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      devDataQ  <= 32'd0;
      devValidQ <= 1'b0;
      errorQ    <= 1'b0;
      statusVal <= 32'd0;
      counter   <= '0;
    end else begin
      state     <= nextState;
      devDataQ  <= devDataNext;
      devValidQ <= devValidNext;
      errorQ    <= errorNext;
      statusVal <= statusNext;
      counter   <= counterNext;
    end
  end

  // Next-state and next-register logic for the transfer sequence.
  // When a timeout and a finish land on the same cycle, the finish wins.
  // When SEND times out, the handshake is abandoned.
  always_comb begin
    nextState    = state;
    devDataNext  = devDataQ;
    devValidNext = devValidQ;
    errorNext    = errorQ;
    statusNext   = statusVal;
    counterNext  = counter;
    case (state)
      IDLE: begin
        if (deviceStore) begin
          devDataNext = bus.dataIn;
          statusNext  = STATUS_BUSY;
          errorNext   = 1'b0;
          nextState   = SET_BUSY;
        end
      end
      SET_BUSY: begin
        counterNext  = '0;
        devValidNext = 1'b1;
        nextState    = SEND;
      end
      SEND: begin
        counterNext = counterInc;
        if (timeoutHit) begin
          statusNext   = STATUS_ERROR;
          errorNext    = 1'b1;
          devValidNext = 1'b0;
          nextState    = CLR_BUSY;
        end else if (bus.devReady) begin
          devValidNext = 1'b0;
          nextState    = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        counterNext = counterInc;
        if (bus.devFinish) begin
          statusNext = STATUS_DONE;
          nextState  = CLR_BUSY;
        end else if (timeoutHit) begin
          statusNext   = STATUS_ERROR;
          errorNext    = 1'b1;
          devValidNext = 1'b0;
          nextState    = CLR_BUSY;
        end
      end
      CLR_BUSY: begin
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // Memory port mux. During the two status-write cycles the controller
  // owns the port. Otherwise the CPU passes straight through, except
  // that device stores never reach memory.
  always_comb begin
    bus.memWriteOut = bus.memWriteIn && !deviceStore;
    bus.readDataOut = bus.readDataIn;
    bus.addressOut  = bus.addressIn;
    bus.dataOut     = bus.dataIn;
    if (ownsPort) begin
      bus.memWriteOut = 1'b1;
      bus.readDataOut = 1'b0;
      bus.addressOut  = STATUS_ADDR;
      bus.dataOut     = statusVal;
    end
  end

  // Stall the CPU in two cases. The first is any access while the
  // controller owns the port. The second is a device store that arrives
  // while a transfer is already in flight.
  always_comb begin
    bus.cpuStall = 1'b0;
    if (ownsPort) begin
      bus.cpuStall = bus.memWriteIn || bus.readDataIn;
    end else if (state != IDLE) begin
      bus.cpuStall = deviceStore;
    end
  end

  assign bus.devData  = devDataQ;
  assign bus.devValid = devValidQ;
  assign bus.error    = errorQ;
  assign bus.busy     = (state != IDLE);

endmodule
